// File: rtl/emulib_dmamodel_pkg.sv
// Shared constants and helpers for the emulib DMA model arbiter and its slices.
// Requester count, downstream ID layout and AXI burst/response encodings.
package emulib_dmamodel_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Downstream IDs are {requester index, sub-ID}; the index sits just above the sub-ID.
    function automatic int id_msb(input int sub_id_width);
        return sub_id_width;
    endfunction

endpackage

// File: rtl/emulib_dmamodel_rr_slice.sv
// Two-way round-robin arbiter feeding a single registered AXI address slot.
// Used for both AR and AW; AW uses i_stall to hold off grants while W routing is full.
module emulib_dmamodel_rr_slice
    import emulib_dmamodel_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           i_valid,
    output logic [NUM_REQ-1:0]           o_ready,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] i_payload,
    input  logic                         i_stall,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_idx,
    output logic [PAYLOAD_W-1:0]         o_payload
);

    logic                 r_active;
    logic                 r_valid;
    logic                 r_rr;
    logic                 r_idx;
    logic [PAYLOAD_W-1:0] r_payload;
    logic                 w_sel;
    logic                 w_grant;

    always_comb begin
        w_sel   = (&i_valid) ? r_rr : i_valid[1];
        w_grant = r_active && (|i_valid) && (!r_valid || i_ready) && !i_stall;
        o_ready = '0;
        o_ready[w_sel] = w_grant;
    end

    // r_active keeps every ready low while reset is held, since readies are built from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_valid  <= 1'b0;
            r_rr     <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_grant) begin
                r_valid <= 1'b1;
                r_rr    <= ~w_sel;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // NOTE: payload and index carry no reset; r_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_idx     <= w_sel;
            r_payload <= w_sel ? i_payload[PAYLOAD_W +: PAYLOAD_W] : i_payload[0 +: PAYLOAD_W];
        end
    end

    assign o_valid   = r_valid;
    assign o_idx     = r_idx;
    assign o_payload = r_payload;

endmodule

// File: rtl/emulib_dmamodel_arbiter.sv
// Two-requester AXI arbiter in front of the DMA model frontend: round-robin AR/AW,
// W routed in AW order through a small index FIFO, R/B routed back by the ID MSB.
module emulib_dmamodel_arbiter
    import emulib_dmamodel_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int SUB_ID_WIDTH = 3,
    parameter int WFIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // upstream AR
    input  logic [1:0]                    s_arvalid,
    output logic [1:0]                    s_arready,
    input  logic [2*ADDR_WIDTH-1:0]       s_araddr,
    input  logic [2*SUB_ID_WIDTH-1:0]     s_arid,
    input  logic [15:0]                   s_arlen,
    input  logic [5:0]                    s_arsize,
    input  logic [3:0]                    s_arburst,
    input  logic [5:0]                    s_arprot,
    // upstream AW
    input  logic [1:0]                    s_awvalid,
    output logic [1:0]                    s_awready,
    input  logic [2*ADDR_WIDTH-1:0]       s_awaddr,
    input  logic [2*SUB_ID_WIDTH-1:0]     s_awid,
    input  logic [15:0]                   s_awlen,
    input  logic [5:0]                    s_awsize,
    input  logic [3:0]                    s_awburst,
    input  logic [5:0]                    s_awprot,
    // upstream W
    input  logic [1:0]                    s_wvalid,
    output logic [1:0]                    s_wready,
    input  logic [2*DATA_WIDTH-1:0]       s_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]     s_wstrb,
    input  logic [1:0]                    s_wlast,
    // upstream R
    output logic [1:0]                    s_rvalid,
    input  logic [1:0]                    s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [SUB_ID_WIDTH-1:0]       s_rid,
    output logic                          s_rlast,
    output logic [1:0]                    s_rresp,
    // upstream B
    output logic [1:0]                    s_bvalid,
    input  logic [1:0]                    s_bready,
    output logic [SUB_ID_WIDTH-1:0]       s_bid,
    output logic [1:0]                    s_bresp,
    // downstream AR
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [SUB_ID_WIDTH:0]         m_arid,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [2:0]                    m_arprot,
    // downstream AW
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic [SUB_ID_WIDTH:0]         m_awid,
    output logic [7:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic [2:0]                    m_awprot,
    // downstream W
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [DATA_WIDTH/8-1:0]       m_wstrb,
    output logic                          m_wlast,
    // downstream R
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [SUB_ID_WIDTH:0]         m_rid,
    input  logic                          m_rlast,
    input  logic [1:0]                    m_rresp,
    // downstream B
    input  logic                          m_bvalid,
    output logic                          m_bready,
    input  logic [SUB_ID_WIDTH:0]         m_bid,
    input  logic [1:0]                    m_bresp
);

    localparam int ID_MSB = id_msb(SUB_ID_WIDTH);
    localparam int PL_W   = ADDR_WIDTH + SUB_ID_WIDTH + 16;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(WFIFO_DEPTH);

    logic [NUM_REQ*PL_W-1:0] w_ar_pl;
    logic [NUM_REQ*PL_W-1:0] w_aw_pl;
    logic [PL_W-1:0]         w_ar_out;
    logic [PL_W-1:0]         w_aw_out;
    logic [SUB_ID_WIDTH-1:0] w_ar_sub_id;
    logic [SUB_ID_WIDTH-1:0] w_aw_sub_id;
    logic                    w_ar_idx;
    logic                    w_aw_idx;

    // Payload layout per requester: {prot, burst, size, len, sub_id, addr}
    always_comb begin
        w_ar_pl = '0;
        w_aw_pl = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_ar_pl[k*PL_W +: PL_W] = {s_arprot[k*3 +: 3], s_arburst[k*2 +: 2], s_arsize[k*3 +: 3],
                                       s_arlen[k*8 +: 8], s_arid[k*SUB_ID_WIDTH +: SUB_ID_WIDTH],
                                       s_araddr[k*ADDR_WIDTH +: ADDR_WIDTH]};
            w_aw_pl[k*PL_W +: PL_W] = {s_awprot[k*3 +: 3], s_awburst[k*2 +: 2], s_awsize[k*3 +: 3],
                                       s_awlen[k*8 +: 8], s_awid[k*SUB_ID_WIDTH +: SUB_ID_WIDTH],
                                       s_awaddr[k*ADDR_WIDTH +: ADDR_WIDTH]};
        end
    end

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic           r_wfifo [WFIFO_DEPTH];
    logic           w_empty;
    logic           w_full;
    logic           w_head;
    logic           w_push;
    logic           w_pop;

    emulib_dmamodel_rr_slice #(.PAYLOAD_W(PL_W)) u_ar_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (s_arvalid),
        .o_ready   (s_arready),
        .i_payload (w_ar_pl),
        .i_stall   (1'b0),
        .o_valid   (m_arvalid),
        .i_ready   (m_arready),
        .o_idx     (w_ar_idx),
        .o_payload (w_ar_out)
    );

    emulib_dmamodel_rr_slice #(.PAYLOAD_W(PL_W)) u_aw_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (s_awvalid),
        .o_ready   (s_awready),
        .i_payload (w_aw_pl),
        .i_stall   (w_full),
        .o_valid   (m_awvalid),
        .i_ready   (m_awready),
        .o_idx     (w_aw_idx),
        .o_payload (w_aw_out)
    );

    assign {m_arprot, m_arburst, m_arsize, m_arlen, w_ar_sub_id, m_araddr} = w_ar_out;
    assign {m_awprot, m_awburst, m_awsize, m_awlen, w_aw_sub_id, m_awaddr} = w_aw_out;
    assign m_arid = {w_ar_idx, w_ar_sub_id};
    assign m_awid = {w_aw_idx, w_aw_sub_id};

    // W-routing FIFO: one requester index per accepted AW; the wrap bit separates full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head  = r_wfifo[r_rd_ptr[PTR_W-1:0]];
    assign w_push  = |s_awready;
    assign w_pop   = m_wvalid && m_wready && m_wlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_wfifo[r_wr_ptr[PTR_W-1:0]] <= s_awready[1];
    end

    always_comb begin
        m_wvalid = !w_empty && s_wvalid[w_head];
        m_wdata  = w_head ? s_wdata[DATA_WIDTH +: DATA_WIDTH] : s_wdata[0 +: DATA_WIDTH];
        m_wstrb  = w_head ? s_wstrb[STRB_W +: STRB_W] : s_wstrb[0 +: STRB_W];
        m_wlast  = s_wlast[w_head];
        s_wready = '0;
        s_wready[w_head] = m_wready && !w_empty;
    end

    // R and B return to the requester named by the ID MSB.
    always_comb begin
        s_rvalid = '0;
        s_rvalid[m_rid[ID_MSB]] = m_rvalid;
        m_rready = s_rready[m_rid[ID_MSB]];
        s_bvalid = '0;
        s_bvalid[m_bid[ID_MSB]] = m_bvalid;
        m_bready = s_bready[m_bid[ID_MSB]];
    end

    assign s_rid   = m_rid[SUB_ID_WIDTH-1:0];
    assign s_rdata = m_rdata;
    assign s_rlast = m_rlast;
    assign s_rresp = m_rresp;
    assign s_bid   = m_bid[SUB_ID_WIDTH-1:0];
    assign s_bresp = m_bresp;

endmodule

// File: tb/tb_emulib_dmamodel_arbiter.sv
// Self-checking bench for emulib_dmamodel_arbiter: directed scenarios plus randomized AR
// traffic and R/B routing against a small transaction-level reference model.
module tb_emulib_dmamodel_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]  s_arvalid, s_arready;
    logic [63:0] s_araddr;
    logic [5:0]  s_arid;
    logic [15:0] s_arlen;
    logic [5:0]  s_arsize;
    logic [3:0]  s_arburst;
    logic [5:0]  s_arprot;
    logic [1:0]  s_awvalid, s_awready;
    logic [63:0] s_awaddr;
    logic [5:0]  s_awid;
    logic [15:0] s_awlen;
    logic [5:0]  s_awsize;
    logic [3:0]  s_awburst;
    logic [5:0]  s_awprot;
    logic [1:0]  s_wvalid, s_wready;
    logic [127:0] s_wdata;
    logic [15:0] s_wstrb;
    logic [1:0]  s_wlast;
    logic [1:0]  s_rvalid, s_rready;
    logic [63:0] s_rdata;
    logic [2:0]  s_rid;
    logic        s_rlast;
    logic [1:0]  s_rresp;
    logic [1:0]  s_bvalid, s_bready;
    logic [2:0]  s_bid;
    logic [1:0]  s_bresp;

    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [2:0]  m_arprot;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [2:0]  m_awprot;
    logic        m_wvalid, m_wready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast;
    logic        m_rvalid, m_rready;
    logic [63:0] m_rdata;
    logic [3:0]  m_rid;
    logic        m_rlast;
    logic [1:0]  m_rresp;
    logic        m_bvalid, m_bready;
    logic [3:0]  m_bid;
    logic [1:0]  m_bresp;

    int n_checks = 0;
    int n_fail   = 0;

    emulib_dmamodel_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .SUB_ID_WIDTH(3), .WFIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arprot(s_arprot),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rlast(s_rlast),
        .s_rresp(s_rresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arprot(m_arprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
        .m_rresp(m_rresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arprot = '0;
        s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awprot = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
        s_rready = '0; s_bready = '0;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rlast = 1'b0; m_rresp = '0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    endtask

    // Leaves the bench at a falling edge, one rising edge after reset release.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        s_arvalid = 2'b11; s_awvalid = 2'b11; s_wvalid = 2'b11;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_arvalid got=%b exp=0", m_arvalid); end
        n_checks++; if (m_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_awvalid got=%b exp=0", m_awvalid); end
        n_checks++; if (m_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_wvalid got=%b exp=0", m_wvalid); end
        n_checks++; if (s_arready !== 2'b00) begin n_fail++; $display("FAIL reset_s_arready got=%b exp=00", s_arready); end
        n_checks++; if (s_awready !== 2'b00) begin n_fail++; $display("FAIL reset_s_awready got=%b exp=00", s_awready); end
        n_checks++; if (s_wready !== 2'b00) begin n_fail++; $display("FAIL reset_s_wready got=%b exp=00", s_wready); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ar_simultaneous();
        apply_reset();
        s_araddr = {32'h0000_2000, 32'h0000_1000};
        s_arid   = {3'd3, 3'd5};
        s_arlen  = {8'd7, 8'd2};
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        #1;
        n_checks++; if (s_arready !== 2'b01) begin n_fail++; $display("FAIL sim_first_ready got=%b exp=01", s_arready); end
        @(negedge clk);
        s_arvalid = 2'b10;
        n_checks++; if ({m_arvalid, m_araddr, m_arid, m_arlen} !== {1'b1, 32'h1000, 4'b0101, 8'd2}) begin
            n_fail++; $display("FAIL sim_first_out got v=%b a=%h id=%b len=%0d exp v=1 a=1000 id=0101 len=2", m_arvalid, m_araddr, m_arid, m_arlen);
        end
        #1;
        n_checks++; if (s_arready !== 2'b10) begin n_fail++; $display("FAIL sim_second_ready got=%b exp=10", s_arready); end
        @(negedge clk);
        s_arvalid = 2'b00;
        n_checks++; if ({m_arvalid, m_araddr, m_arid, m_arlen} !== {1'b1, 32'h2000, 4'b1011, 8'd7}) begin
            n_fail++; $display("FAIL sim_second_out got v=%b a=%h id=%b len=%0d exp v=1 a=2000 id=1011 len=7", m_arvalid, m_araddr, m_arid, m_arlen);
        end
        @(negedge clk);
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL sim_drain got=%b exp=0", m_arvalid); end
    endtask

    task automatic test_ar_backpressure();
        apply_reset();
        s_araddr  = {32'h0000_B000, 32'h0000_A000};
        s_arid    = {3'd1, 3'd2};
        s_arvalid = 2'b11;
        m_arready = 1'b0;
        #1;
        n_checks++; if (s_arready !== 2'b01) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=01", s_arready); end
        @(negedge clk);
        s_arvalid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({m_arvalid, m_araddr, m_arid} !== {1'b1, 32'hA000, 4'b0010}) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b a=%h id=%b exp v=1 a=a000 id=0010", i, m_arvalid, m_araddr, m_arid);
            end
            #1;
            n_checks++; if (s_arready !== 2'b00) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=00", i, s_arready); end
            @(negedge clk);
        end
        m_arready = 1'b1;
        #1;
        n_checks++; if (s_arready !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=10", s_arready); end
        @(negedge clk);
        s_arvalid = 2'b00;
        n_checks++; if ({m_arvalid, m_araddr, m_arid} !== {1'b1, 32'hB000, 4'b1001}) begin
            n_fail++; $display("FAIL bp_second_out got v=%b a=%h id=%b exp v=1 a=b000 id=1001", m_arvalid, m_araddr, m_arid);
        end
        @(negedge clk);
        n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", m_arvalid); end
    endtask

    task automatic test_w_ordering();
        logic [63:0] d1, d0;
        logic [7:0]  st;
        apply_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        s_awaddr = {32'h0000_3000, 32'h0000_4000};
        s_awid   = {3'd6, 3'd4};
        s_awlen  = {8'd3, 8'd1};
        s_awvalid = 2'b10;
        #1;
        n_checks++; if (s_awready !== 2'b10) begin n_fail++; $display("FAIL wo_aw1_ready got=%b exp=10", s_awready); end
        @(negedge clk);
        s_awvalid = 2'b01;
        n_checks++; if ({m_awvalid, m_awid, m_awlen} !== {1'b1, 4'b1110, 8'd3}) begin
            n_fail++; $display("FAIL wo_aw1_out got v=%b id=%b len=%0d exp v=1 id=1110 len=3", m_awvalid, m_awid, m_awlen);
        end
        #1;
        n_checks++; if (s_awready !== 2'b01) begin n_fail++; $display("FAIL wo_aw0_ready got=%b exp=01", s_awready); end
        @(negedge clk);
        s_awvalid = 2'b00;
        n_checks++; if ({m_awvalid, m_awid, m_awlen} !== {1'b1, 4'b0100, 8'd1}) begin
            n_fail++; $display("FAIL wo_aw0_out got v=%b id=%b len=%0d exp v=1 id=0100 len=1", m_awvalid, m_awid, m_awlen);
        end
        s_wvalid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            d1 = {$urandom, $urandom}; d0 = {$urandom, $urandom}; st = 8'($urandom);
            s_wdata = {d1, d0};
            s_wstrb = {st, 8'h00};
            s_wlast = {(b == 3), 1'b0};
            #1;
            n_checks++; if ({m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready} !== {1'b1, d1, st, (b == 3), 2'b10}) begin
                n_fail++; $display("FAIL wo_req1_beat%0d got v=%b d=%h s=%h l=%b rdy=%b exp v=1 d=%h s=%h l=%b rdy=10",
                                   b, m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready, d1, st, (b == 3));
            end
            @(negedge clk);
        end
        s_wvalid = 2'b01;
        for (int b = 0; b < 2; b++) begin
            d0 = {$urandom, $urandom};
            s_wdata = {64'h0, d0};
            s_wlast = {1'b0, (b == 1)};
            #1;
            n_checks++; if ({m_wvalid, m_wdata, m_wlast, s_wready} !== {1'b1, d0, (b == 1), 2'b01}) begin
                n_fail++; $display("FAIL wo_req0_beat%0d got v=%b d=%h l=%b rdy=%b exp v=1 d=%h l=%b rdy=01",
                                   b, m_wvalid, m_wdata, m_wlast, s_wready, d0, (b == 1));
            end
            @(negedge clk);
        end
        s_wvalid = 2'b11; s_wlast = 2'b00;
        #1;
        n_checks++; if ({m_wvalid, s_wready} !== 3'b000) begin
            n_fail++; $display("FAIL wo_empty got v=%b rdy=%b exp v=0 rdy=00", m_wvalid, s_wready);
        end
        s_wvalid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_fifo_full();
        apply_reset();
        m_awready = 1'b1; m_wready = 1'b0;
        s_awvalid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            s_awaddr = {32'h0, 32'(i * 16)};
            #1;
            n_checks++; if (s_awready !== 2'b01) begin n_fail++; $display("FAIL ff_fill%0d got=%b exp=01", i, s_awready); end
            @(negedge clk);
        end
        s_awaddr = {32'h0, 32'h50};
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (s_awready !== 2'b00) begin n_fail++; $display("FAIL ff_stall%0d got=%b exp=00", i, s_awready); end
            @(negedge clk);
        end
        s_wvalid = 2'b01; s_wlast = 2'b01; m_wready = 1'b1;
        #1;
        n_checks++; if ({s_wready, s_awready} !== 4'b0100) begin
            n_fail++; $display("FAIL ff_pop_cycle got wrdy=%b awrdy=%b exp wrdy=01 awrdy=00", s_wready, s_awready);
        end
        @(negedge clk);
        s_wvalid = 2'b00; s_wlast = 2'b00; m_wready = 1'b0;
        #1;
        n_checks++; if (s_awready !== 2'b01) begin n_fail++; $display("FAIL ff_after_pop got=%b exp=01", s_awready); end
        @(negedge clk);
        s_awvalid = 2'b00;
        n_checks++; if ({m_awvalid, m_awaddr} !== {1'b1, 32'h50}) begin
            n_fail++; $display("FAIL ff_fifth_out got v=%b a=%h exp v=1 a=50", m_awvalid, m_awaddr);
        end
    endtask

    task automatic test_random_ar();
        logic        slot_v;
        logic [31:0] slot_addr;
        logic [3:0]  slot_id;
        logic [7:0]  slot_len;
        logic [2:0]  slot_prot;
        logic [1:0]  pend;
        logic [31:0] p_addr [2];
        logic [2:0]  p_id   [2];
        logic [7:0]  p_len  [2];
        logic [2:0]  p_prot [2];
        logic        grant;
        logic [1:0]  exp_rdy;
        int          prio;
        int          win;
        apply_reset();
        slot_v = 1'b0; slot_addr = '0; slot_id = '0; slot_len = '0; slot_prot = '0;
        pend = 2'b00; prio = 0;
        for (int k = 0; k < 2; k++) begin p_addr[k] = '0; p_id[k] = '0; p_len[k] = '0; p_prot[k] = '0; end
        for (int c = 0; c < 300; c++) begin
            n_checks++; if (m_arvalid !== slot_v) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, m_arvalid, slot_v); end
            if (slot_v) begin
                n_checks++; if ({m_araddr, m_arid, m_arlen, m_arprot} !== {slot_addr, slot_id, slot_len, slot_prot}) begin
                    n_fail++; $display("FAIL rnd_payload cyc=%0d got a=%h id=%b len=%0d p=%0d exp a=%h id=%b len=%0d p=%0d",
                                       c, m_araddr, m_arid, m_arlen, m_arprot, slot_addr, slot_id, slot_len, slot_prot);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 2) != 0) begin
                    pend[k] = 1'b1; p_addr[k] = $urandom; p_id[k] = 3'($urandom);
                    p_len[k] = 8'($urandom); p_prot[k] = 3'($urandom);
                end
            end
            s_arvalid = pend;
            s_araddr  = {p_addr[1], p_addr[0]};
            s_arid    = {p_id[1], p_id[0]};
            s_arlen   = {p_len[1], p_len[0]};
            s_arprot  = {p_prot[1], p_prot[0]};
            m_arready = ($urandom_range(0, 3) != 0);
            #1;
            grant   = (pend != 2'b00) && (!slot_v || m_arready);
            win     = (pend == 2'b11) ? prio : (pend[1] ? 1 : 0);
            exp_rdy = grant ? 2'(1 << win) : 2'b00;
            n_checks++; if (s_arready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, s_arready, exp_rdy); end
            if (grant) begin
                slot_v = 1'b1; slot_addr = p_addr[win]; slot_id = {1'(win), p_id[win]};
                slot_len = p_len[win]; slot_prot = p_prot[win];
                pend[win] = 1'b0; prio = 1 - win;
            end else if (m_arready) begin
                slot_v = 1'b0;
            end
            @(negedge clk);
        end
        s_arvalid = 2'b00;
    endtask

    task automatic test_rb_routing();
        logic [63:0] d;
        logic [1:0]  exp_v;
        logic [1:0]  rdy;
        d = {$urandom, $urandom};
        m_rid = 4'b1010; m_rvalid = 1'b1; s_rready = 2'b01; m_rdata = d; m_rlast = 1'b1; m_rresp = 2'b10;
        m_bid = 4'b1010; m_bvalid = 1'b1; s_bready = 2'b01; m_bresp = 2'b11;
        #1;
        n_checks++; if ({s_rvalid, s_rid, m_rready, s_rdata, s_rlast, s_rresp} !== {2'b10, 3'b010, 1'b0, d, 1'b1, 2'b10}) begin
            n_fail++; $display("FAIL rb_r_directed got v=%b id=%b rdy=%b d=%h l=%b resp=%b exp v=10 id=010 rdy=0 d=%h l=1 resp=10",
                               s_rvalid, s_rid, m_rready, s_rdata, s_rlast, s_rresp, d);
        end
        n_checks++; if ({s_bvalid, s_bid, m_bready, s_bresp} !== {2'b10, 3'b010, 1'b0, 2'b11}) begin
            n_fail++; $display("FAIL rb_b_directed got v=%b id=%b rdy=%b resp=%b exp v=10 id=010 rdy=0 resp=11",
                               s_bvalid, s_bid, m_bready, s_bresp);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            m_rid = 4'($urandom); m_rvalid = 1'($urandom); s_rready = 2'($urandom); m_rdata = {$urandom, $urandom};
            m_bid = 4'($urandom); m_bvalid = 1'($urandom); s_bready = 2'($urandom);
            #1;
            exp_v = m_rvalid ? ((m_rid >= 4'd8) ? 2'b10 : 2'b01) : 2'b00;
            rdy = s_rready;
            n_checks++; if ({s_rvalid, s_rid, m_rready, s_rdata} !== {exp_v, 3'(m_rid % 8), rdy[m_rid / 8], m_rdata}) begin
                n_fail++; $display("FAIL rb_r_rand%0d got v=%b id=%b rdy=%b exp v=%b id=%b rdy=%b",
                                   i, s_rvalid, s_rid, m_rready, exp_v, 3'(m_rid % 8), rdy[m_rid / 8]);
            end
            exp_v = m_bvalid ? ((m_bid >= 4'd8) ? 2'b10 : 2'b01) : 2'b00;
            rdy = s_bready;
            n_checks++; if ({s_bvalid, s_bid, m_bready} !== {exp_v, 3'(m_bid % 8), rdy[m_bid / 8]}) begin
                n_fail++; $display("FAIL rb_b_rand%0d got v=%b id=%b rdy=%b exp v=%b id=%b rdy=%b",
                                   i, s_bvalid, s_bid, m_bready, exp_v, 3'(m_bid % 8), rdy[m_bid / 8]);
            end
        end
        m_rvalid = 1'b0; m_bvalid = 1'b0; s_rready = '0; s_bready = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        apply_reset();
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        s_arvalid = 2'b01;
        #1;
        n_checks++; if (s_arready !== 2'b01) begin n_fail++; $display("FAIL mr_pre_ar got=%b exp=01", s_arready); end
        @(negedge clk);
        s_arvalid = 2'b00;
        s_awvalid = 2'b01; s_awlen = {8'd0, 8'd3};
        @(negedge clk);
        s_awvalid = 2'b00;
        s_wvalid = 2'b01; s_wlast = 2'b00;
        for (int b = 0; b < 2; b++) begin
            #1;
            n_checks++; if (s_wready !== 2'b01) begin n_fail++; $display("FAIL mr_beat%0d got=%b exp=01", b, s_wready); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        s_arvalid = 2'b11; s_awvalid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if ({m_arvalid, m_awvalid, m_wvalid, s_wready, s_arready, s_awready} !== 9'b0) begin
                n_fail++; $display("FAIL mr_in_reset%0d got arv=%b awv=%b wv=%b wrdy=%b arrdy=%b awrdy=%b exp all 0",
                                   i, m_arvalid, m_awvalid, m_wvalid, s_wready, s_arready, s_awready);
            end
            @(negedge clk);
        end
        s_arvalid = 2'b00; s_awvalid = 2'b00; s_wvalid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        s_wvalid = 2'b01;
        s_arvalid = 2'b11;
        #1;
        n_checks++; if ({s_arready, m_wvalid} !== 3'b010) begin
            n_fail++; $display("FAIL mr_after_release got arrdy=%b wv=%b exp arrdy=01 wv=0", s_arready, m_wvalid);
        end
        @(negedge clk);
        s_arvalid = 2'b00; s_wvalid = 2'b00;
        n_checks++; if ({m_arvalid, m_arid[3]} !== 2'b10) begin
            n_fail++; $display("FAIL mr_fresh_ar got v=%b msb=%b exp v=1 msb=0", m_arvalid, m_arid[3]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ar_simultaneous();
        test_ar_backpressure();
        test_w_ordering();
        test_fifo_full();
        test_random_ar();
        test_rb_routing();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
